pellet_tracker: RTL

- Downstream consumer of the player position produced by the player movement stage.
- Holds the 20x15 tile pellet bitmap (32-px tiles on the 640x480 board). When the player sits exactly on a tile centre it eats that tile's pellet and updates the score.
- Signals level clear and serves a one-cycle-latency pellet query port to the sprite/board renderer.
- Runs on the same frame-rate clock as the movement stage.

---
 rtl/pellet_tracker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pellet_tracker.sv
// Pellet bitmap, score and level tracking for the player position stream.
// Eating is two-stage: register the tile under the player, then consume it.
module pellet_tracker #(
   parameter int unsigned TILE_COLS = 20,
   parameter int unsigned TILE_ROWS = 15,
   parameter logic [TILE_COLS*TILE_ROWS-1:0] PELLET_MASK = '1,
   parameter logic [TILE_COLS*TILE_ROWS-1:0] POWER_MASK =
      (300'd1 << 21) | (300'd1 << 38) | (300'd1 << 261) | (300'd1 << 278),
   parameter int unsigned PELLET_PTS = 10,
   parameter int unsigned POWER_PTS  = 50
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  playerX,
   input  logic [9:0]  playerY,
   input  logic        newLevel,
   input  logic [4:0]  qCol,
   input  logic [3:0]  qRow,
   output logic [1:0]  qPellet,
   output logic [15:0] score,
   output logic [8:0]  pelletsLeft,
   output logic        eatPulse,
   output logic        powerPulse,
   output logic        ready,
   output logic        levelClear,
   output logic [3:0]  level
);

   localparam int unsigned N_TILES  = TILE_COLS * TILE_ROWS;
   localparam logic [8:0]  LAST_IDX = 9'(N_TILES - 1);

   typedef enum logic [1:0] {S_INIT, S_PLAY, S_CLEAR} state_t;

   state_t              r_state;
   logic [N_TILES-1:0]  r_bitmap;
   logic [8:0]          r_init_idx;
   logic [15:0]         r_score;
   logic [8:0]          r_left;
   logic [3:0]          r_level;
   logic [1:0]          r_q;
   logic                r_eat;
   logic                r_pow;
   logic                r_ready;
   logic                r_clear;
   logic                r_at_centre;
   logic [8:0]          r_tile_idx;

   logic [4:0]  w_col;
   logic [4:0]  w_row;
   logic        w_at_centre;
   logic [8:0]  w_tile_idx;
   logic        w_q_valid;
   logic [8:0]  w_q_idx;
   logic [8:0]  w_q_sel;
   logic        w_eat_hit;
   logic [16:0] w_eat_pts;
   logic [16:0] w_score_sum;

   // Stage-1 tile decode; off-board or off-centre positions never form an index
   assign w_col       = playerX[9:5];
   assign w_row       = playerY[9:5];
   assign w_at_centre = (playerX[4:0] == 5'd0) && (playerY[4:0] == 5'd0) &&
                        (w_col < 5'(TILE_COLS)) && (w_row < 5'(TILE_ROWS));
   assign w_tile_idx  = 9'(w_row) * 9'(TILE_COLS) + 9'(w_col);

   assign w_q_valid   = (qCol < 5'(TILE_COLS)) && (qRow < 4'(TILE_ROWS));
   assign w_q_idx     = 9'(qRow) * 9'(TILE_COLS) + 9'(qCol);
   assign w_q_sel     = w_q_valid ? w_q_idx : 9'd0;

   assign w_eat_hit   = (r_state == S_PLAY) && r_at_centre && r_bitmap[r_tile_idx];
   assign w_eat_pts   = POWER_MASK[r_tile_idx] ? 17'(POWER_PTS) : 17'(PELLET_PTS);
   assign w_score_sum = {1'b0, r_score} + w_eat_pts;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state     <= S_INIT;
         r_bitmap    <= '0;
         r_init_idx  <= 9'd0;
         r_score     <= 16'd0;
         r_left      <= 9'd0;
         r_level     <= 4'd0;
         r_q         <= 2'b00;
         r_eat       <= 1'b0;
         r_pow       <= 1'b0;
         r_ready     <= 1'b0;
         r_clear     <= 1'b0;
         r_at_centre <= 1'b0;
         r_tile_idx  <= 9'd0;
      end else begin
         r_eat       <= 1'b0;
         r_pow       <= 1'b0;
         r_at_centre <= (r_state == S_PLAY) && w_at_centre;
         r_tile_idx  <= w_at_centre ? w_tile_idx : 9'd0;

         // Query reads the pre-update bitmap, so a same-edge eat returns the old value
         if ((r_state != S_INIT) && w_q_valid)
            r_q <= {r_bitmap[w_q_sel] & POWER_MASK[w_q_sel],
                    r_bitmap[w_q_sel] & ~POWER_MASK[w_q_sel]};
         else
            r_q <= 2'b00;

         case (r_state)
            S_INIT: begin
               r_bitmap[r_init_idx] <= PELLET_MASK[r_init_idx];
               if (PELLET_MASK[r_init_idx])
                  r_left <= r_left + 9'd1;
               if (r_init_idx == LAST_IDX) begin
                  r_state <= S_PLAY;
                  r_ready <= 1'b1;
               end else begin
                  r_init_idx <= r_init_idx + 9'd1;
               end
            end
            S_PLAY: begin
               if (w_eat_hit) begin
                  r_bitmap[r_tile_idx] <= 1'b0;
                  r_left               <= r_left - 9'd1;
                  r_score              <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                  r_eat                <= 1'b1;
                  r_pow                <= POWER_MASK[r_tile_idx];
                  if (r_left == 9'd1) begin
                     r_state <= S_CLEAR;
                     r_ready <= 1'b0;
                     r_clear <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               if (newLevel) begin
                  if (r_level != 4'hF)
                     r_level <= r_level + 4'd1;
                  r_left     <= 9'd0;
                  r_init_idx <= 9'd0;
                  r_clear    <= 1'b0;
                  r_state    <= S_INIT;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign qPellet     = r_q;
   assign score       = r_score;
   assign pelletsLeft = r_left;
   assign eatPulse    = r_eat;
   assign powerPulse  = r_pow;
   assign ready       = r_ready;
   assign levelClear  = r_clear;
   assign level       = r_level;

endmodule
